alu_control_unit: RTL and testbench

ALU_CONTROL_UNIT -- requirements
Module: alu_control

---
 rtl/alu_control_unit.sv | 174 +++++++++++++++++
 tb/tb_alu_control_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// Main control and ALU-control decoder: one registered decode of instr per clock, no state between instructions.
// Optional macro ALU_CONTROL_MULDIV_EN enables the mul/div/mfhi/mflo funct codes (otherwise they are illegal).
module alu_control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic [1:0]  ALUOp,
  output logic [5:0]  func,
  output logic        RegDST,
  output logic        BEQ,
  output logic        BNE,
  output logic        JMP,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        LUI,
  output logic        SysEnable,
  output logic [2:0]  ALUCtl,
  output logic        Illegal
);

  localparam int B_REGDST = 10;
  localparam int B_BEQ    = 9;
  localparam int B_BNE    = 8;
  localparam int B_JMP    = 7;
  localparam int B_MRD    = 6;
  localparam int B_M2R    = 5;
  localparam int B_MWR    = 4;
  localparam int B_ASRC   = 3;
  localparam int B_RWR    = 2;
  localparam int B_LUI    = 1;
  localparam int B_SYS    = 0;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [10:0] ctl_d, ctl_q;
  logic [1:0]  aluop_d, aluop_q;
  logic [2:0]  aluctl_d, aluctl_q;
  logic [5:0]  func_d, func_q;
  logic        illegal_d, illegal_q;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign func_d = funct;

  always_comb begin
    ctl_d     = '0;
    aluop_d   = 2'b00;
    illegal_d = 1'b0;
    case (opcode)
      6'h00: begin
        aluop_d = 2'b10;
        case (funct)
          6'h20, 6'h22, 6'h2A: begin
            ctl_d[B_REGDST] = 1'b1;
            ctl_d[B_RWR]    = 1'b1;
          end
`ifdef ALU_CONTROL_MULDIV_EN
          6'h10, 6'h12: begin
            ctl_d[B_REGDST] = 1'b1;
            ctl_d[B_RWR]    = 1'b1;
          end
          6'h18, 6'h1A: ; // HI/LO write is handled inside the datapath
`endif
          6'h08: ctl_d[B_JMP] = 1'b1;
          6'h0C: ctl_d[B_SYS] = 1'b1;
          6'h00: ;
          default: illegal_d = 1'b1;
        endcase
      end
      6'h04: begin
        ctl_d[B_BEQ] = 1'b1;
        aluop_d      = 2'b01;
      end
      6'h05: begin
        ctl_d[B_BNE] = 1'b1;
        aluop_d      = 2'b01;
      end
      6'h23: begin
        ctl_d[B_MRD]  = 1'b1;
        ctl_d[B_M2R]  = 1'b1;
        ctl_d[B_ASRC] = 1'b1;
        ctl_d[B_RWR]  = 1'b1;
      end
      6'h25: begin
        ctl_d[B_MWR]  = 1'b1;
        ctl_d[B_ASRC] = 1'b1;
      end
      6'h0F: begin
        ctl_d[B_LUI]  = 1'b1;
        ctl_d[B_ASRC] = 1'b1;
        ctl_d[B_RWR]  = 1'b1;
      end
      6'h0D: begin
        ctl_d[B_ASRC] = 1'b1;
        ctl_d[B_RWR]  = 1'b1;
        aluop_d       = 2'b11;
      end
      6'h08: begin
        ctl_d[B_ASRC] = 1'b1;
        ctl_d[B_RWR]  = 1'b1;
      end
      6'h02: ctl_d[B_JMP] = 1'b1;
      6'h03: begin
        // jal links to $31, so RegDST stays low
        ctl_d[B_JMP] = 1'b1;
        ctl_d[B_RWR] = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    if (illegal_d) begin
      ctl_d   = '0;
      aluop_d = 2'b00;
    end
  end

  always_comb begin
    aluctl_d = 3'b000;
    case (aluop_d)
      2'b00: aluctl_d = 3'b010;
      2'b01: aluctl_d = 3'b110;
      2'b11: aluctl_d = 3'b001;
      default: begin
        case (funct)
          6'h20:   aluctl_d = 3'b010;
          6'h22:   aluctl_d = 3'b110;
          6'h2A:   aluctl_d = 3'b001;
          6'h18:   aluctl_d = 3'b011;
          6'h1A:   aluctl_d = 3'b100;
          6'h10:   aluctl_d = 3'b101;
          6'h12:   aluctl_d = 3'b111;
          default: aluctl_d = 3'b000;
        endcase
      end
    endcase
    // illegal decodes force ALUOp=00, which would otherwise map to add
    if (illegal_d) aluctl_d = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q     <= '0;
      aluop_q   <= 2'b00;
      aluctl_q  <= 3'b000;
      func_q    <= 6'b000000;
      illegal_q <= 1'b0;
    end else begin
      ctl_q     <= ctl_d;
      aluop_q   <= aluop_d;
      aluctl_q  <= aluctl_d;
      func_q    <= func_d;
      illegal_q <= illegal_d;
    end
  end

  assign RegDST    = ctl_q[B_REGDST];
  assign BEQ       = ctl_q[B_BEQ];
  assign BNE       = ctl_q[B_BNE];
  assign JMP       = ctl_q[B_JMP];
  assign MemRead   = ctl_q[B_MRD];
  assign MemtoReg  = ctl_q[B_M2R];
  assign MemWrite  = ctl_q[B_MWR];
  assign ALUSrc    = ctl_q[B_ASRC];
  assign RegWrite  = ctl_q[B_RWR];
  assign LUI       = ctl_q[B_LUI];
  assign SysEnable = ctl_q[B_SYS];
  assign ALUOp     = aluop_q;
  assign ALUCtl    = aluctl_q;
  assign func      = func_q;
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed-vector bench for alu_control_unit; expected values are hand-computed per instruction.
// Honours ALU_CONTROL_MULDIV_EN so the mul/div/mfhi/mflo expectations match the build.
module tb_alu_control_unit;

  localparam logic [10:0] C_REGDST = 11'h400;
  localparam logic [10:0] C_BEQ    = 11'h200;
  localparam logic [10:0] C_BNE    = 11'h100;
  localparam logic [10:0] C_JMP    = 11'h080;
  localparam logic [10:0] C_MRD    = 11'h040;
  localparam logic [10:0] C_M2R    = 11'h020;
  localparam logic [10:0] C_MWR    = 11'h010;
  localparam logic [10:0] C_ASRC   = 11'h008;
  localparam logic [10:0] C_RWR    = 11'h004;
  localparam logic [10:0] C_LUI    = 11'h002;
  localparam logic [10:0] C_SYS    = 11'h001;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [1:0]  ALUOp;
  logic [5:0]  func;
  logic        RegDST, BEQ, BNE, JMP, MemRead, MemtoReg, MemWrite;
  logic        ALUSrc, RegWrite, LUI, SysEnable;
  logic [2:0]  ALUCtl;
  logic        Illegal;

  int total;
  int bad;

  alu_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .ALUOp(ALUOp), .func(func),
    .RegDST(RegDST), .BEQ(BEQ), .BNE(BNE), .JMP(JMP),
    .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .LUI(LUI), .SysEnable(SysEnable),
    .ALUCtl(ALUCtl), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive at negedge, let one rising edge sample it, look #1 later.
  task automatic step(input logic [31:0] iw, input logic rn);
    @(negedge clk);
    instr = iw;
    rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] iw, input logic [10:0] ctl,
                            input logic [1:0] aop, input logic [2:0] actl, input logic [5:0] fn,
                            input logic ill);
    logic [10:0] ctl_obs;
    ctl_obs = {RegDST, BEQ, BNE, JMP, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, LUI, SysEnable};
    check({tag, ".ctl"},     {21'b0, ctl_obs}, {21'b0, ctl});
    check({tag, ".aluop"},   {30'b0, ALUOp},   {30'b0, aop});
    check({tag, ".aluctl"},  {29'b0, ALUCtl},  {29'b0, actl});
    check({tag, ".func"},    {26'b0, func},    {26'b0, fn});
    check({tag, ".illegal"}, {31'b0, Illegal}, {31'b0, ill});
    $display("txn %-10s instr=%08h ctl=%03h aluop=%0d aluctl=%0d func=%02h ill=%0b",
             tag, iw, ctl_obs, ALUOp, ALUCtl, func, Illegal);
  endtask

  task automatic vec(input string tag, input logic [31:0] iw, input logic [10:0] ctl,
                     input logic [1:0] aop, input logic [2:0] actl, input logic ill);
    step(iw, 1'b1);
    expect_out(tag, iw, ctl, aop, actl, iw[5:0], ill);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    instr = 32'h0;
    rst_n = 1'b0;

    // reset overrides a live lw, then release decodes it
    step(32'h8C000000, 1'b0);
    expect_out("reset", 32'h8C000000, 11'h000, 2'b00, 3'b000, 6'h00, 1'b0);
    vec("lw",    32'h8C000000, C_MRD | C_M2R | C_ASRC | C_RWR, 2'b00, 3'b010, 1'b0);
    vec("beq",   32'h10000000, C_BEQ,  2'b01, 3'b110, 1'b0);
    vec("bne",   32'h14000000, C_BNE,  2'b01, 3'b110, 1'b0);
    vec("ori",   32'h34000000, C_ASRC | C_RWR, 2'b11, 3'b001, 1'b0);
    vec("lui",   32'h3C000000, C_LUI | C_ASRC | C_RWR, 2'b00, 3'b010, 1'b0);
    vec("sw",    32'h94000000, C_MWR | C_ASRC, 2'b00, 3'b010, 1'b0);
    vec("addi",  32'h2000002A, C_ASRC | C_RWR, 2'b00, 3'b010, 1'b0);
    vec("j",     32'h08000012, C_JMP, 2'b00, 3'b010, 1'b0);
    vec("jal",   32'h0C000000, C_JMP | C_RWR, 2'b00, 3'b010, 1'b0);

    vec("add",   32'h00000020, C_REGDST | C_RWR, 2'b10, 3'b010, 1'b0);
    vec("sub",   32'h00000022, C_REGDST | C_RWR, 2'b10, 3'b110, 1'b0);
    vec("or",    32'h0000002A, C_REGDST | C_RWR, 2'b10, 3'b001, 1'b0);
`ifdef ALU_CONTROL_MULDIV_EN
    vec("mul",   32'h00000018, 11'h000, 2'b10, 3'b011, 1'b0);
    vec("div",   32'h0000001A, 11'h000, 2'b10, 3'b100, 1'b0);
    vec("mfhi",  32'h00000010, C_REGDST | C_RWR, 2'b10, 3'b101, 1'b0);
    vec("mflo",  32'h00000012, C_REGDST | C_RWR, 2'b10, 3'b111, 1'b0);
`else
    vec("mul",   32'h00000018, 11'h000, 2'b00, 3'b000, 1'b1);
    vec("div",   32'h0000001A, 11'h000, 2'b00, 3'b000, 1'b1);
    vec("mfhi",  32'h00000010, 11'h000, 2'b00, 3'b000, 1'b1);
    vec("mflo",  32'h00000012, 11'h000, 2'b00, 3'b000, 1'b1);
`endif
    vec("syscall", 32'h0000000C, C_SYS, 2'b10, 3'b000, 1'b0);
    vec("jr",    32'h00000008, C_JMP, 2'b10, 3'b000, 1'b0);
    vec("nop",   32'h00000000, 11'h000, 2'b10, 3'b000, 1'b0);
    vec("badop", 32'hFC000000, 11'h000, 2'b00, 3'b000, 1'b1);
    vec("badfn", 32'h0000003F, 11'h000, 2'b00, 3'b000, 1'b1);

    // mid-stream reset discards an in-flight R-type decode
    vec("pre_rst", 32'h00000020, C_REGDST | C_RWR, 2'b10, 3'b010, 1'b0);
    step(32'h0000002A, 1'b0);
    expect_out("mid_rst", 32'h0000002A, 11'h000, 2'b00, 3'b000, 6'h00, 1'b0);
    vec("post_rst", 32'h00000022, C_REGDST | C_RWR, 2'b10, 3'b110, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
